// File: rtl/ysyx_22041412_mdu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_mdu_pkg
// Shared constants for the iterative RV64M multiply/divide unit:
//   - default operand width and iteration counter width
//   - RV64M funct3 encodings
//   - FSM state encoding (IDLE / BUSY / DONE)
// ---------------------------------------------------------------------------
package ysyx_22041412_mdu_pkg;

  localparam int MDU_XLEN  = 64;
  localparam int MDU_CNT_W = 7;

  // RV64M funct3 codes. Bit 2 separates divide (1) from multiply (0);
  // for divides bit 1 selects remainder and bit 0 selects unsigned.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/ysyx_22041412_mdu_fixup.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_mdu_fixup
// Purely combinational helper for the MDU.
//   Prep side (from the request):
//     i_funct3, i_is_word, i_src1, i_src2 -> operand magnitudes o_mag1/o_mag2,
//     result sign flags o_neg_q/o_neg_r, special-case flag and value.
//   Fixup side (from the finished iteration register):
//     i_op, i_op_word, i_op_neg_q, i_op_neg_r, i_acc -> o_result with sign
//     correction, high/low product selection and W-form sign extension.
// Optional macro YSYX_22041412_MDU_EARLY_EXIT_EN: a zero multiplier is
// reported as a special case (result 0, no iterations).
// ---------------------------------------------------------------------------
module ysyx_22041412_mdu_fixup
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic [2:0]        i_funct3,
  input  logic              i_is_word,
  input  logic [XLEN-1:0]   i_src1,
  input  logic [XLEN-1:0]   i_src2,
  output logic [XLEN-1:0]   o_mag1,
  output logic [XLEN-1:0]   o_mag2,
  output logic              o_neg_q,
  output logic              o_neg_r,
  output logic              o_special,
  output logic [XLEN-1:0]   o_special_res,
  input  logic [2:0]        i_op,
  input  logic              i_op_word,
  input  logic              i_op_neg_q,
  input  logic              i_op_neg_r,
  input  logic [2*XLEN-1:0] i_acc,
  output logic [XLEN-1:0]   o_result
);

  localparam int HALF = XLEN / 2;

  logic            w_div, w_signed1, w_signed2, w_neg1, w_neg2;
  logic            w_b_zero, w_ovf;
  logic [XLEN-1:0] w_a, w_b, w_dividend;

  // NOTE: every signal written in an always_comb block gets a default at the
  // top so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_div = i_funct3[2];
    if (w_div) begin
      w_signed1 = ~i_funct3[0];
      w_signed2 = ~i_funct3[0];
    end else begin
      // Every W-form multiply is MULW: only the low half is kept, so the
      // operand signs never matter there.
      w_signed1 = ~i_is_word & ((i_funct3 == F3_MULH) | (i_funct3 == F3_MULHSU));
      w_signed2 = ~i_is_word & (i_funct3 == F3_MULH);
    end

    w_a = i_src1;
    w_b = i_src2;
    if (i_is_word) begin
      w_a = w_signed1 ? {{HALF{i_src1[HALF-1]}}, i_src1[HALF-1:0]}
                      : {{HALF{1'b0}}, i_src1[HALF-1:0]};
      w_b = w_signed2 ? {{HALF{i_src2[HALF-1]}}, i_src2[HALF-1:0]}
                      : {{HALF{1'b0}}, i_src2[HALF-1:0]};
    end

    w_neg1  = w_signed1 & w_a[XLEN-1];
    w_neg2  = w_signed2 & w_b[XLEN-1];
    o_mag1  = w_neg1 ? -w_a : w_a;
    o_mag2  = w_neg2 ? -w_b : w_b;
    o_neg_q = w_neg1 ^ w_neg2;
    o_neg_r = w_neg1;

    // Special divides are judged in the operand domain (32 or 64 bit).
    w_dividend = i_is_word ? {{HALF{i_src1[HALF-1]}}, i_src1[HALF-1:0]} : i_src1;
    w_b_zero   = i_is_word ? (i_src2[HALF-1:0] == '0) : (i_src2 == '0);
    w_ovf      = w_div & w_signed1 &
                 (i_is_word ? ((i_src1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}}) & (&i_src2[HALF-1:0]))
                            : ((i_src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&i_src2)));

    o_special     = w_div & (w_b_zero | w_ovf);
    o_special_res = '0;
    if (w_b_zero)
      o_special_res = i_funct3[1] ? w_dividend : '1;
    else if (w_ovf)
      o_special_res = i_funct3[1] ? '0 : w_dividend;

`ifdef YSYX_22041412_MDU_EARLY_EXIT_EN
    if (!w_div && (o_mag2 == '0)) begin
      o_special     = 1'b1;
      o_special_res = '0;
    end
`endif
  end

  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_res;

  always_comb begin
    // A W multiply ran HALF iterations, leaving its product HALF bits up.
    w_prod = i_op_word ? (i_acc >> HALF) : i_acc;
    if (i_op_neg_q)
      w_prod = -w_prod;
    w_quo = i_op_neg_q ? -i_acc[XLEN-1:0]      : i_acc[XLEN-1:0];
    w_rem = i_op_neg_r ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];

    if (!i_op[2])
      w_res = (i_op_word || (i_op == F3_MUL)) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    else
      w_res = i_op[1] ? w_rem : w_quo;

    o_result = i_op_word ? {{HALF{w_res[HALF-1]}}, w_res[HALF-1:0]} : w_res;
  end

endmodule

// File: rtl/ysyx_22041412_mdu.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_mdu
// Iterative RV64M multiply/divide unit (one bit per cycle) beside the ALU.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   funct3, is_word       RV64M operation, W form select
//   src1, src2            operands
//   flush                 abort in-flight op, back to IDLE
//   out_valid / out_ready result handshake (valid only in DONE)
//   result                final result, held stable in DONE
//   busy                  stall hint, high whenever not IDLE
// Optional macro YSYX_22041412_MDU_EARLY_EXIT_EN: multiplies leave BUSY as
// soon as the remaining multiplier bits are all zero.
// ---------------------------------------------------------------------------
module ysyx_22041412_mdu
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = MDU_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic            is_word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int HALF = XLEN / 2;

  mdu_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_is_word, r_neg_q, r_neg_r, r_special;
  logic [XLEN-1:0]   r_mcand;   // multiplicand, or divisor magnitude
  logic [XLEN-1:0]   r_mplier;  // remaining multiplier bits
  logic [2*XLEN-1:0] r_acc;     // product, or {remainder, quotient}
  logic [XLEN-1:0]   r_result;

  logic [XLEN-1:0]   w_mag1, w_mag2, w_special_res, w_fix_result, w_dvd;
  logic              w_neg_q, w_neg_r, w_special;
  logic              w_accept, w_finish, w_step, w_last, w_early;
  logic [CNT_W-1:0]  w_n;
  logic [2*XLEN-1:0] w_acc_fix;

  ysyx_22041412_mdu_fixup #(.XLEN(XLEN)) u_fixup (
    .i_funct3      (funct3),
    .i_is_word     (is_word),
    .i_src1        (src1),
    .i_src2        (src2),
    .o_mag1        (w_mag1),
    .o_mag2        (w_mag2),
    .o_neg_q       (w_neg_q),
    .o_neg_r       (w_neg_r),
    .o_special     (w_special),
    .o_special_res (w_special_res),
    .i_op          (r_op),
    .i_op_word     (r_is_word),
    .i_op_neg_q    (r_neg_q),
    .i_op_neg_r    (r_neg_r),
    .i_acc         (w_acc_fix),
    .o_result      (w_fix_result)
  );

  assign w_n   = r_is_word ? CNT_W'(HALF) : CNT_W'(XLEN);
  assign w_dvd = is_word ? (w_mag1 << HALF) : w_mag1;

`ifdef YSYX_22041412_MDU_EARLY_EXIT_EN
  // The skipped iterations only shift; apply them all at once on exit.
  assign w_early   = ~r_op[2] & (r_mplier == '0);
  assign w_acc_fix = r_acc >> (w_n - r_cnt);
`else
  assign w_early   = 1'b0;
  assign w_acc_fix = r_acc;
`endif

  // Special cases still spend one cycle in BUSY so every op captures its
  // result on the same BUSY->DONE edge.
  assign w_last = r_special | (r_cnt == w_n) | w_early;

  // Shift-add multiply step: add the multiplicand into the high half when
  // the current multiplier bit is set, then shift the product right.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_step;
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_mplier[0] ? r_mcand : '0)};
  assign w_mul_step = {w_sum, r_acc[XLEN-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract when it fits. The partial remainder stays below twice the
  // divisor, so the top difference bit is a pure borrow flag.
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_step;
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_mcand};
  assign w_ge       = ~w_diff[XLEN];
  assign w_div_step = {(w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_step      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_step = 1'b1;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (flush || out_ready)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_op      <= '0;
      r_is_word <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_special <= 1'b0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_result  <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= funct3;
      r_is_word <= is_word;
      r_neg_q   <= w_neg_q;
      r_neg_r   <= w_neg_r;
      r_special <= w_special;
      r_mcand   <= funct3[2] ? w_mag2 : w_mag1;
      r_mplier  <= w_mag2;
      // W divides pre-shift the dividend so its MSB enters first.
      r_acc     <= funct3[2] ? {{XLEN{1'b0}}, w_dvd} : '0;
      if (w_special)
        r_result <= w_special_res;
    end else if (w_finish) begin
      if (!r_special)
        r_result <= w_fix_result;
    end else if (w_step) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= r_op[2] ? w_div_step : w_mul_step;
      r_mplier <= r_mplier >> 1;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_ysyx_22041412_mdu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041412_mdu
// Directed self-checking bench for the RV64M multiply/divide unit.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_mdu;

`ifdef YSYX_22041412_MDU_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  funct3 = 3'b000;
  logic        is_word = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  ysyx_22041412_mdu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .is_word   (is_word),
    .src1      (src1),
    .src2      (src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Drive one request; returns 1ns after the accepting edge.
  task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    funct3 = f3; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges after acceptance until out_valid; -1 when the bound expires.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/busy=%b result=%h expected 100 / 0", {in_ready, out_valid, busy}, result);
    end
    rst_n = 1'b1;
  endtask

  task automatic run_table(input vec_t v[$]);
    int lat;
    foreach (v[i]) begin
      start_op(v[i].f3, v[i].w, v[i].a, v[i].b);
      wait_done(lat);
      n_tests++;
      if (result !== v[i].exp) begin
        n_fail++;
        $display("FAIL %s result: got %h expected %h", v[i].name, result, v[i].exp);
      end
      n_tests++;
      if (lat !== v[i].lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", v[i].name, lat, v[i].lat);
      end
      take_result();
    end
  endtask

  task automatic test_mul();
    vec_t v[$];
    v.push_back('{"mul_7x-3",     3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65});
    v.push_back('{"mulhu_ones_x2", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, EE ? 3 : 65});
    v.push_back('{"mulh_-1x-1",   3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, EE ? 2 : 65});
    v.push_back('{"mulhsu_-1x2",  3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, EE ? 3 : 65});
    v.push_back('{"mulhu_2^32sq", 3'b011, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, EE ? 34 : 65});
    v.push_back('{"mul_by_zero",  3'b000, 1'b0, 64'd123, 64'd0, 64'd0, EE ? 1 : 65});
    v.push_back('{"mulw_7fff_x2", 3'b000, 1'b1, 64'hAAAA_AAAA_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, EE ? 3 : 33});
    v.push_back('{"mulh_word_3x5", 3'b001, 1'b1, 64'd3, 64'd5, 64'd15, EE ? 4 : 33});
    run_table(v);
  endtask

  task automatic test_div();
    vec_t v[$];
    v.push_back('{"div_-7/2",     3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65});
    v.push_back('{"rem_-7/2",     3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65});
    v.push_back('{"divuw_8000/1", 3'b101, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33});
    v.push_back('{"remu_100/7",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65});
    v.push_back('{"divu_ones/16", 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65});
    v.push_back('{"divw_7/-2",    3'b100, 1'b1, 64'h1234_0000_0000_0007, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 33});
    v.push_back('{"remw_-7/2",    3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33});
    run_table(v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{"div_5/0",      3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{"remu_5/0",     3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1});
    v.push_back('{"div_min/-1",   3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1});
    v.push_back('{"remw_min/-1",  3'b110, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1});
    v.push_back('{"divw_min/-1",  3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1});
    v.push_back('{"divuw_5/0",    3'b101, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    v.push_back('{"remw_neg/0",   3'b110, 1'b1, 64'h0000_0000_8000_0003, 64'd0, 64'hFFFF_FFFF_8000_0003, 1});
    run_table(v);
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(3'b101, 1'b0, 64'd100, 64'd7);
    wait_done(lat);
    // A competing request during the hold must be ignored.
    @(negedge clk);
    funct3 = 3'b000; is_word = 1'b0; src1 = 64'd2; src2 = 64'd2; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'd14) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: vld=%b rdy=%b result=%h expected 1 0 %h", i, out_valid, in_ready, result, 64'd14);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handoff_no_accept: busy=%b rdy=%b vld=%b expected 0 1 0", busy, in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    start_op(3'b100, 1'b0, 64'd1000, 64'd3);
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_midop: busy=%b rdy=%b expected 1 0", busy, in_ready);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy: busy=%b rdy=%b vld=%b expected 0 1 0", busy, in_ready, out_valid);
    end
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: out_valid seen=%b expected 0", seen);
    end
    // flush wins over out_ready in DONE
    start_op(3'b100, 1'b0, 64'd5, 64'd0);
    wait_done(lat);
    @(negedge clk);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL flush_done: vld=%b busy=%b lat=%0d expected 0 0 1", out_valid, busy, lat);
    end
    // flush with in_valid in IDLE: not accepted
    @(negedge clk);
    funct3 = 3'b100; src1 = 64'd9; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_idle_req: busy=%b rdy=%b expected 0 1", busy, in_ready);
    end
  endtask

  task automatic test_reset_midop();
    int lat;
    start_op(3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_midop: rdy/vld/busy=%b result=%h expected 100 / 0", {in_ready, out_valid, busy}, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start_op(3'b000, 1'b0, 64'd3, 64'd5);
    wait_done(lat);
    n_tests++;
    if (result !== 64'd15 || lat < 1) begin
      n_fail++;
      $display("FAIL mul_after_reset: result=%h lat=%0d expected %h", result, lat, 64'd15);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_flush();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_22041412_mdu.md
Name: ysyx_22041412_mdu

Overview:
- Iterative RV64M multiply/divide unit that sits beside the ALU in the EX stage.
- The ALU keeps single-cycle integer ops. This block sequences the multi-cycle MUL*/DIV*/REM* ops (incl. W forms) one bit per cycle.
- Valid/ready handshakes toward decode and toward writeback; the EX stage stalls while the unit is busy.
- A flush input aborts an in-flight op on redirect.

Parameters:
- XLEN, 64, operand/result width.
- CNT_W, 7, iteration counter width (must hold XLEN).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  unit can accept (state IDLE)
- funct3  input  3  RV64M funct3 (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU)
- is_word  input  1  opcode is RV64_R (W form); only MULW/DIVW/DIVUW/REMW/REMUW are legal
- src1  input  XLEN  rs1 value
- src2  input  XLEN  rs2 value
- flush  input  1  abort current op, return to IDLE
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  XLEN  final result (W forms sign-extended from bit 31)
- busy  output  1  state is not IDLE (stall hint)

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; in_ready=1; out_valid=0; busy=0; result=0; counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch operands, op and is_word; go to BUSY, or to DONE for special cases.
  - BUSY: one iteration per cycle; counter increments. After N iterations (N=64, or 32 if is_word), go to DONE.
  - DONE: out_valid=1; result held stable. On out_ready, go to IDLE.
- Latency: accept on edge T → out_valid high from edge T+N+1. Special cases → out_valid from edge T+1.
- Operand prep: W forms use src[31:0], sign- or zero-extended per op. Signed ops use magnitudes; signs are recorded for fixup.
- Multiply: shift-add over N iterations; 2N-bit product register.
  - MUL/MULW return the low half.
  - MULH* return the high half of the sign-corrected 128-bit product.
  - MULHSU treats src1 as signed and src2 as unsigned.
- Divide: restoring, one quotient bit per iteration.
  - Quotient sign = sign1 XOR sign2.
  - Remainder sign = sign1.
- Special cases (no iterations):
  - Divisor zero: quotient = all ones (W: 0xFFFFFFFF_FFFFFFFF after sign-extend); remainder = dividend.
  - Signed overflow (most-negative / -1, in the 64- or 32-bit domain): quotient = dividend; remainder = 0.
- Back-pressure: DONE is held indefinitely while out_ready=0; in_ready stays 0.
- in_valid is sampled only in IDLE. No new op is accepted in the same cycle that DONE hands off; the next accept is in IDLE the cycle after.
- flush:
  - In BUSY or DONE: go to IDLE next edge; out_valid drops; the result is discarded.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush has priority over out_ready.
- Illegal is_word with MULH*: treated as MULW (defined result, no error).
- An asynchronous reset mid-operation returns to IDLE immediately; no partial result is ever presented.

Optional Feature:
- YSYX_22041412_MDU_EARLY_EXIT_EN defined: multiply ops leave BUSY as soon as the remaining multiplier bits are all zero. The remaining shifts are applied in one cycle, so latency = (index of highest set multiplier bit)+2 cycles, minimum 2. A zero multiplier goes straight to DONE (latency 1).
- Undefined: fixed N iterations for all multiplies. Divide latency is unchanged either way.

Decomposition:
- Shared constants go in ysyx_22041412_define.v: MDU funct3 codes, state encodings (IDLE/BUSY/DONE), XLEN.
- One sub-module, ysyx_22041412_mdu_fixup: combinational operand sign/magnitude prep and final result sign correction, W sign-extension and special-case muxing.
- The top keeps the FSM, counter and shift registers.

Test Plan:
- MUL 7×(-3), is_word=0 → result 0xFFFFFFFF_FFFFFFEB; out_valid at T+65 (without EARLY_EXIT).
- MULHU 0xFFFFFFFF_FFFFFFFF×2 → result 0x1; MULH -1×-1 → 0x0; MULHSU -1×2 → 0xFFFFFFFF_FFFFFFFF.
- DIV -7/2 → result -3; REM -7/2 → result -1; DIVUW 0x80000000/1 → result 0xFFFFFFFF_80000000; DIVUW out_valid at T+33.
- DIV 5/0 → 0xFFFFFFFF_FFFFFFFF; REMU 5/0 → 5; DIV 0x80000000_00000000/-1 → same value; REMW 0x80000000/-1 → 0; all at T+1.
- Hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0; then flush asserted mid-BUSY on a new DIV → IDLE next cycle, no out_valid.
- Assert rst_n low at iteration 20 of DIVU → outputs at reset values immediately; a following MUL 3×5 returns 15.
